// File: rtl/display_scan_controller_pkg.sv
// Shared constants and helpers for the 4-digit multiplexed 7-segment scan controller.
package display_pkg;

  localparam int NUM_DIGITS = 4;
  localparam logic [3:0] ANODE_OFF = 4'b1111;

  // One-hot-low anode pattern for a digit index (digit 0 is the rightmost).
  function automatic logic [3:0] anode_decode(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/display_scan_controller_timer.sv
// Slot timing for the display scan: per-slot cycle counter, digit index and frame strobes.
module scan_slot_timer #(
  parameter int SLOT_CYCLES = 100000,
  parameter int CNT_W       = 17
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic [CNT_W-1:0] slot_cnt,
  output logic [1:0]       digit_idx,
  output logic             frame_wrap,
  output logic             frame_begin
);

  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SLOT_CYCLES - 1);

  logic slot_wrap;

  assign slot_wrap   = (slot_cnt == SLOT_LAST);
  assign frame_wrap  = en && slot_wrap && (digit_idx == 2'd3);
  assign frame_begin = en && (slot_cnt == '0) && (digit_idx == 2'd0);

  // Disabling parks the scan at the start of digit 0 so re-enabling begins a fresh frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_cnt  <= '0;
      digit_idx <= 2'd0;
    end else if (!en) begin
      slot_cnt  <= '0;
      digit_idx <= 2'd0;
    end else if (slot_wrap) begin
      slot_cnt  <= '0;
      digit_idx <= digit_idx + 2'd1;
    end else begin
      slot_cnt <= slot_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/display_scan_controller.sv
// 4-digit common-anode display scanner: frame-synchronous value buffering, PWM brightness
// window with leading blank gap, leading-zero suppression and registered outputs.
module display_scan_controller
  import display_pkg::*;
#(
  parameter int SLOT_CYCLES  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic                    load,
  input  logic [2:0]              brightness,
  input  logic                    lz_en,
  output logic [3:0]              anode,
  output logic [1:0]              digit_sel,
  output logic [3:0]              digit_val,
  output logic                    frame_start
);

  localparam int CNT_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam logic [31:0] BLANK_U = BLANK_CYCLES;
  localparam logic [31:0] STEP_U  = (SLOT_CYCLES - BLANK_CYCLES) / 8;

  logic [CNT_W-1:0]        slot_cnt;
  logic [1:0]              digit_idx;
  logic                    frame_wrap;
  logic                    frame_begin;
  logic [2:0]              bright_q;
  logic [2:0]              bright_eff;
  logic [4*NUM_DIGITS-1:0] shadow;
  logic [4*NUM_DIGITS-1:0] display;
  logic                    pending;
  logic [31:0]             slot_ext;
  logic [31:0]             lit_end;
  logic                    in_window;
  logic                    lz_blank;
  logic [3:0]              cur_nibble;

  scan_slot_timer #(
    .SLOT_CYCLES(SLOT_CYCLES),
    .CNT_W      (CNT_W)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .slot_cnt   (slot_cnt),
    .digit_idx  (digit_idx),
    .frame_wrap (frame_wrap),
    .frame_begin(frame_begin)
  );

  // Brightness is latched at slot start; bypassing the register on that cycle keeps
  // the whole slot consistent even when the blank gap is zero length.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bright_q <= 3'd0;
    end else if (slot_cnt == '0) begin
      bright_q <= brightness;
    end
  end

  // A load coinciding with the frame wrap bypasses the shadow so it is not lost a frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow  <= '0;
      display <= '0;
      pending <= 1'b0;
    end else if (load && frame_wrap) begin
      shadow  <= value_in;
      display <= value_in;
      pending <= 1'b0;
    end else if (load) begin
      shadow  <= value_in;
      pending <= 1'b1;
    end else if (frame_wrap && pending) begin
      display <= shadow;
      pending <= 1'b0;
    end
  end

  always_comb begin
    bright_eff = (slot_cnt == '0) ? brightness : bright_q;
    slot_ext   = 32'(slot_cnt);
    lit_end    = BLANK_U + (32'(bright_eff) + 32'd1) * STEP_U;
    in_window  = (slot_ext >= BLANK_U) && (slot_ext < lit_end);
    cur_nibble = display[{digit_idx, 2'b00} +: 4];
    lz_blank   = 1'b0;
    case (digit_idx)
      2'd3:    lz_blank = lz_en && (display[15:12] == 4'd0);
      2'd2:    lz_blank = lz_en && (display[15:8] == 8'd0);
      2'd1:    lz_blank = lz_en && (display[15:4] == 12'd0);
      default: lz_blank = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      anode       <= ANODE_OFF;
      digit_sel   <= 2'd0;
      digit_val   <= 4'd0;
      frame_start <= 1'b0;
    end else begin
      anode       <= (en && in_window && !lz_blank) ? anode_decode(digit_idx) : ANODE_OFF;
      digit_sel   <= digit_idx;
      digit_val   <= cur_nibble;
      frame_start <= frame_begin;
    end
  end

endmodule

// File: tb/tb_display_scan_controller.sv
// Directed bench for display_scan_controller with 20-cycle slots, 4-cycle blank gap (STEP = 2).
module tb_display_scan_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b1;
  logic [15:0] value_in = 16'h0000;
  logic        load = 1'b0;
  logic [2:0]  brightness = 3'd7;
  logic        lz_en = 1'b0;
  logic [3:0]  anode;
  logic [1:0]  digit_sel;
  logic [3:0]  digit_val;
  logic        frame_start;

  int check_count = 0;
  int fail_count = 0;
  int edge_no = 0;

  always #5 clk = ~clk;

  display_scan_controller #(
    .SLOT_CYCLES (20),
    .BLANK_CYCLES(4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .value_in   (value_in),
    .load       (load),
    .brightness (brightness),
    .lz_en      (lz_en),
    .anode      (anode),
    .digit_sel  (digit_sel),
    .digit_val  (digit_val),
    .frame_start(frame_start)
  );

  // Edge numbering: edge 1 is the first rising edge after reset release.
  task automatic advance_to(input int target);
    while (edge_no < target) begin
      @(posedge clk);
      edge_no++;
    end
    #1;
  endtask

  task automatic check_output(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    check_count++;
    assert (obs === exp)
    else begin
      fail_count++;
      $error("[TB] FAIL %s at edge %0d: observed %h expected %h", tag, edge_no, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [15:0] v);
    value_in = v;
    load = 1'b1;
    advance_to(edge_no + 1);
    load = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_output("rst_anode", 16'(anode), 16'hF);
    check_output("rst_sel", 16'(digit_sel), 16'h0);
    check_output("rst_val", 16'(digit_val), 16'h0);
    check_output("rst_fs", 16'(frame_start), 16'h0);
    reset = 1'b0;
    edge_no = 0;

    // Full brightness, first frame still shows the reset value.
    advance_to(1);
    check_output("e1_fs", 16'(frame_start), 16'h1);
    check_output("e1_anode", 16'(anode), 16'hF);
    apply_stimulus(16'h1234);
    advance_to(4);
    check_output("e4_blank", 16'(anode), 16'hF);
    advance_to(5);
    check_output("e5_lit", 16'(anode), 16'hE);
    check_output("e5_val_old", 16'(digit_val), 16'h0);
    advance_to(20);
    check_output("e20_lit", 16'(anode), 16'hE);
    advance_to(21);
    check_output("e21_blank", 16'(anode), 16'hF);
    check_output("e21_sel", 16'(digit_sel), 16'h1);
    check_output("e21_fs", 16'(frame_start), 16'h0);
    advance_to(80);
    check_output("e80_fs", 16'(frame_start), 16'h0);
    advance_to(81);
    check_output("e81_fs", 16'(frame_start), 16'h1);
    check_output("e81_val", 16'(digit_val), 16'h4);
    advance_to(85);
    check_output("e85_anode", 16'(anode), 16'hE);
    advance_to(105);
    check_output("e105_anode", 16'(anode), 16'hD);
    check_output("e105_val", 16'(digit_val), 16'h3);
    advance_to(125);
    check_output("e125_anode", 16'(anode), 16'hB);
    check_output("e125_val", 16'(digit_val), 16'h2);
    advance_to(145);
    check_output("e145_anode", 16'(anode), 16'h7);
    check_output("e145_val", 16'(digit_val), 16'h1);
    advance_to(160);
    check_output("e160_anode", 16'(anode), 16'h7);
    advance_to(161);
    check_output("e161_fs", 16'(frame_start), 16'h1);

    // Minimum brightness from the digit 1 slot; mid-slot change applies next slot.
    brightness = 3'd0;
    advance_to(184);
    check_output("b0_e184", 16'(anode), 16'hF);
    advance_to(185);
    check_output("b0_e185", 16'(anode), 16'hD);
    advance_to(186);
    check_output("b0_e186", 16'(anode), 16'hD);
    advance_to(187);
    check_output("b0_e187", 16'(anode), 16'hF);
    advance_to(190);
    brightness = 3'd3;
    advance_to(192);
    check_output("b3_same_slot", 16'(anode), 16'hF);
    advance_to(212);
    check_output("b3_e212", 16'(anode), 16'hB);
    advance_to(213);
    check_output("b3_e213", 16'(anode), 16'hF);

    // Two loads mid-frame: last one wins at the frame boundary.
    advance_to(219);
    apply_stimulus(16'h1111);
    advance_to(224);
    apply_stimulus(16'h2222);
    advance_to(230);
    check_output("hold_val", 16'(digit_val), 16'h1);
    check_output("hold_anode", 16'(anode), 16'h7);
    advance_to(241);
    check_output("swap_fs", 16'(frame_start), 16'h1);
    check_output("swap_val", 16'(digit_val), 16'h2);

    // Load on the boundary edge goes straight to the display.
    advance_to(319);
    apply_stimulus(16'h3333);
    advance_to(321);
    check_output("bnd_fs", 16'(frame_start), 16'h1);
    check_output("bnd_val", 16'(digit_val), 16'h3);

    // Leading-zero suppression.
    lz_en = 1'b1;
    advance_to(329);
    apply_stimulus(16'h0050);
    advance_to(405);
    check_output("lz_d0_anode", 16'(anode), 16'hE);
    check_output("lz_d0_val", 16'(digit_val), 16'h0);
    advance_to(425);
    check_output("lz_d1_anode", 16'(anode), 16'hD);
    check_output("lz_d1_val", 16'(digit_val), 16'h5);
    advance_to(445);
    check_output("lz_d2_anode", 16'(anode), 16'hF);
    check_output("lz_d2_sel", 16'(digit_sel), 16'h2);
    advance_to(465);
    check_output("lz_d3_anode", 16'(anode), 16'hF);
    check_output("lz_d3_sel", 16'(digit_sel), 16'h3);
    advance_to(469);
    apply_stimulus(16'h0000);
    advance_to(485);
    check_output("lz0_d0_anode", 16'(anode), 16'hE);
    advance_to(505);
    check_output("lz0_d1_anode", 16'(anode), 16'hF);
    check_output("lz0_d1_sel", 16'(digit_sel), 16'h1);

    // Disable for 30 cycles mid-slot, then restart from digit 0.
    advance_to(510);
    en = 1'b0;
    advance_to(511);
    check_output("dis_e511_anode", 16'(anode), 16'hF);
    check_output("dis_e511_fs", 16'(frame_start), 16'h0);
    advance_to(525);
    check_output("dis_e525_anode", 16'(anode), 16'hF);
    check_output("dis_e525_sel", 16'(digit_sel), 16'h0);
    advance_to(540);
    check_output("dis_e540_anode", 16'(anode), 16'hF);
    check_output("dis_e540_fs", 16'(frame_start), 16'h0);
    en = 1'b1;
    advance_to(541);
    check_output("ren_fs", 16'(frame_start), 16'h1);
    check_output("ren_anode", 16'(anode), 16'hF);
    advance_to(544);
    check_output("ren_blank", 16'(anode), 16'hF);
    advance_to(545);
    check_output("ren_lit", 16'(anode), 16'hE);

    // Asynchronous reset during a lit cycle.
    #2;
    reset = 1'b1;
    #1;
    check_output("arst_anode", 16'(anode), 16'hF);
    check_output("arst_sel", 16'(digit_sel), 16'h0);
    check_output("arst_val", 16'(digit_val), 16'h0);
    check_output("arst_fs", 16'(frame_start), 16'h0);
    #10;
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", check_count, fail_count);
    $finish;
  end

endmodule
